nes_mem_mp: RTL and testbench

Parametrised, multi-read-port synchronous memory for the NES design. It generalises the existing single-port instruction memory with the following features:
- configurable data/address width, physical depth and read-port count;
- NES-style address mirroring;
- selectable 1- or 2-cycle read latency;
- selectable write-first/read-first collision mode;
- a post-reset clear sequencer.

It serves as the CPU work RAM (2 KB mirrored across 8 KB), as PPU nametable RAM, or as a shared program memory read by the CPU fetch and DMA paths in parallel.

---
 rtl/nes_mem_mp.sv | 141 ++++++++++++++
 tb/tb_nes_mem_mp.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/nes_mem_mp.sv
// Multi-read-port synchronous RAM with NES-style address mirroring, 1/2-cycle read
// latency, selectable collision behaviour and a post-reset clear sequencer.
module nes_mem_mp #(
  parameter int                 DATA_W         = 8,
  parameter int                 ADDR_W         = 16,
  parameter int                 DEPTH_LOG2     = 11,
  parameter int                 RD_PORTS       = 2,
  parameter int                 RD_LAT         = 1,
  parameter int                 WRITE_FIRST    = 1,
  parameter int                 CLEAR_ON_RESET = 1,
  parameter logic [DATA_W-1:0]  CLEAR_VAL      = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [RD_PORTS*ADDR_W-1:0]   raddr,
  output logic [RD_PORTS*DATA_W-1:0]   rdata,
  input  logic                         wen,
  input  logic [ADDR_W-1:0]            waddr,
  input  logic [DATA_W-1:0]            wdata,
  output logic                         ready
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {
    ST_RESET,
    ST_CLEAR,
    ST_RUN
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   ready_q, ready_d;

  logic [DATA_W-1:0]      mem [DEPTH];
  logic                   mem_we;
  logic [DEPTH_LOG2-1:0]  mem_idx;
  logic [DATA_W-1:0]      mem_wval;

  logic [DEPTH_LOG2-1:0]  widx;
  logic [DEPTH_LOG2-1:0]  ridx  [RD_PORTS];
  logic [DATA_W-1:0]      rd1_q [RD_PORTS];
  logic [DATA_W-1:0]      rd1_d [RD_PORTS];

  // Upper address bits only select a mirror; they never reach the array.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{raddr, waddr};

  assign widx  = waddr[DEPTH_LOG2-1:0];
  assign ready = ready_q;

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ready_d  = ready_q;
    mem_we   = 1'b0;
    mem_idx  = widx;
    mem_wval = wdata;
    unique case (state_q)
      ST_RESET: begin
        if (CLEAR_ON_RESET != 0) begin
          state_d = ST_CLEAR;
        end else begin
          state_d = ST_RUN;
          ready_d = 1'b1;
        end
      end
      ST_CLEAR: begin
        mem_we   = 1'b1;
        mem_idx  = cnt_q[DEPTH_LOG2-1:0];
        mem_wval = CLEAR_VAL;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DEPTH - 1)) begin
          state_d = ST_RUN;
          ready_d = 1'b1;
        end
      end
      ST_RUN:   mem_we = wen;
      default:  state_d = ST_RESET;
    endcase
    // A reset edge must never disturb the array contents.
    if (!rst_n) mem_we = 1'b0;
  end

  always_comb begin
    for (int p = 0; p < RD_PORTS; p++) begin
      ridx[p]  = raddr[p*ADDR_W +: DEPTH_LOG2];
      rd1_d[p] = '0;
      if (state_q == ST_RUN) begin
        if ((WRITE_FIRST != 0) && wen && (widx == ridx[p])) rd1_d[p] = wdata;
        else                                                rd1_d[p] = mem[ridx[p]];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_RESET;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      for (int p = 0; p < RD_PORTS; p++) rd1_q[p] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      rd1_q   <= rd1_d;
    end
  end

  // NOTE: the array itself has no reset; its defined contents come from the
  // clear sequencer, which keeps it mappable onto block RAM.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_idx] <= mem_wval;
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic [DATA_W-1:0] rd2_q [RD_PORTS];
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int p = 0; p < RD_PORTS; p++) rd2_q[p] <= '0;
        end else begin
          rd2_q <= rd1_q;
        end
      end
      for (genvar p = 0; p < RD_PORTS; p++) begin : g_out
        assign rdata[p*DATA_W +: DATA_W] = rd2_q[p];
      end
    end else begin : g_lat1
      for (genvar p = 0; p < RD_PORTS; p++) begin : g_out
        assign rdata[p*DATA_W +: DATA_W] = rd1_q[p];
      end
    end
  endgenerate

endmodule

// File: tb/tb_nes_mem_mp.sv
// Bench for nes_mem_mp: two configurations driven with shared write/reset stimulus,
// checked every cycle against a behavioural model plus literal spot checks.
module tb_nes_mem_mp;

  localparam int AW   = 16;
  localparam int DW   = 8;
  localparam int NP_A = 3;
  localparam int NP_B = 2;

  logic                 clk   = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 wen   = 1'b0;
  logic [AW-1:0]        waddr = '0;
  logic [DW-1:0]        wdata = '0;
  logic [AW-1:0]        ra [2][3];

  logic [NP_A*AW-1:0]   raddr_a;
  logic [NP_A*DW-1:0]   rdata_a;
  logic                 ready_a;
  logic [NP_B*AW-1:0]   raddr_b;
  logic [NP_B*DW-1:0]   rdata_b;
  logic                 ready_b;

  assign raddr_a = {ra[0][2], ra[0][1], ra[0][0]};
  assign raddr_b = {ra[1][1], ra[1][0]};

  always #5 clk = ~clk;

  // A: 16 words, 3 ports, 1-cycle, write-first, cleared to 0xA5.
  nes_mem_mp #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH_LOG2(4), .RD_PORTS(NP_A), .RD_LAT(1),
    .WRITE_FIRST(1), .CLEAR_ON_RESET(1), .CLEAR_VAL(8'hA5)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .raddr(raddr_a), .rdata(rdata_a),
    .wen(wen), .waddr(waddr), .wdata(wdata), .ready(ready_a)
  );

  // B: 32 words, 2 ports, 2-cycle, read-first, no clear.
  nes_mem_mp #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH_LOG2(5), .RD_PORTS(NP_B), .RD_LAT(2),
    .WRITE_FIRST(0), .CLEAR_ON_RESET(0), .CLEAR_VAL(8'h00)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .raddr(raddr_b), .rdata(rdata_b),
    .wen(wen), .waddr(waddr), .wdata(wdata), .ready(ready_b)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  function automatic int  depth_of(int d); return (d == 0) ? 16 : 32; endfunction
  function automatic int  lat_of  (int d); return (d == 0) ? 1  : 2;  endfunction
  function automatic bit  wf_of   (int d); return d == 0;            endfunction
  function automatic bit  clr_of  (int d); return d == 0;            endfunction
  function automatic int  ports_of(int d); return (d == 0) ? NP_A : NP_B; endfunction
  // hi = number of consecutive edges seen with rst_n high.
  function automatic bit model_ready(int d, int hi);
    return clr_of(d) ? (hi >= 1 + depth_of(d)) : (hi >= 1);
  endfunction

  logic [DW-1:0] m_mem   [2][32];
  bit            m_known [2][32];
  logic [DW-1:0] s1 [2][3];
  logic [DW-1:0] s2 [2][3];
  bit            k1 [2][3];
  bit            k2 [2][3];
  int            hi_cnt  = 0;
  bit            started = 1'b0;
  int            m_pre, m_dep, m_idx, m_widx;
  bit            m_run;

  always @(posedge clk) begin
    m_pre   = hi_cnt;
    hi_cnt  = !rst_n ? 0 : ((hi_cnt < 1000000) ? hi_cnt + 1 : hi_cnt);
    started = 1'b1;
    for (int d = 0; d < 2; d++) begin
      m_dep  = depth_of(d);
      m_run  = model_ready(d, m_pre);
      m_widx = int'(waddr) % m_dep;
      for (int p = 0; p < ports_of(d); p++) begin
        if (!rst_n) begin
          s1[d][p] = '0; k1[d][p] = 1'b1;
          s2[d][p] = '0; k2[d][p] = 1'b1;
        end else begin
          s2[d][p] = s1[d][p];
          k2[d][p] = k1[d][p];
          if (!m_run) begin
            s1[d][p] = '0; k1[d][p] = 1'b1;
          end else begin
            m_idx = int'(ra[d][p]) % m_dep;
            if (wen && m_widx == m_idx && wf_of(d)) begin
              s1[d][p] = wdata; k1[d][p] = 1'b1;
            end else begin
              s1[d][p] = m_mem[d][m_idx]; k1[d][p] = m_known[d][m_idx];
            end
          end
        end
      end
      if (rst_n && m_run && wen) begin
        m_mem[d][m_widx]   = wdata;
        m_known[d][m_widx] = 1'b1;
      end else if (rst_n && clr_of(d) && m_pre >= 1 && m_pre <= m_dep) begin
        m_mem[d][m_pre-1]   = 8'hA5;
        m_known[d][m_pre-1] = 1'b1;
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      check("ready_a", 32'(ready_a), 32'(model_ready(0, hi_cnt)));
      check("ready_b", 32'(ready_b), 32'(model_ready(1, hi_cnt)));
      for (int p = 0; p < NP_A; p++)
        if (k1[0][p]) check($sformatf("rdata_a[%0d]", p), 32'(rdata_a[p*DW +: DW]), 32'(s1[0][p]));
      for (int p = 0; p < NP_B; p++)
        if (k2[1][p]) check($sformatf("rdata_b[%0d]", p), 32'(rdata_b[p*DW +: DW]), 32'(s2[1][p]));
    end
  end

  // ---------------- directed + random stimulus ----------------
  int cnt;

  initial begin
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 3; p++) ra[d][p] = '0;

    // Reset, then a reset pulse in the middle of the clear with a write pending.
    rst_n = 1'b0; wen = 1'b1; waddr = 16'h0000; wdata = 8'hFF;
    repeat (3) @(negedge clk);
    check("rst_ready_a", 32'(ready_a), 32'd0);
    check("rst_rdata_a", 32'(rdata_a), 32'd0);
    check("rst_rdata_b", 32'(rdata_b), 32'd0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    while (ready_a !== 1'b1 && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    check("clear_len", 32'(cnt), 32'd17);
    wen = 1'b0;

    // Every index holds the clear value on all ports (0xFF never landed).
    for (int i = 0; i < 16; i++) begin
      for (int p = 0; p < NP_A; p++) ra[0][p] = 16'(((i + p) % 16) | (p << 11));
      @(negedge clk);
      check("clr_val_p0", 32'(rdata_a[7:0]), 32'hA5);
    end

    // Mirroring: write 0x0012, read through two mirrors.
    wen = 1'b1; waddr = 16'h0012; wdata = 8'h3C;
    @(negedge clk);
    wen = 1'b0;
    ra[0][0] = 16'h0812; ra[0][1] = 16'h1812;
    ra[1][0] = 16'h0812; ra[1][1] = 16'h1812;
    @(negedge clk);
    check("mirror_a_p0", 32'(rdata_a[7:0]),  32'h3C);
    check("mirror_a_p1", 32'(rdata_a[15:8]), 32'h3C);
    @(negedge clk);
    check("mirror_b_p0", 32'(rdata_b[7:0]),  32'h3C);
    check("mirror_b_p1", 32'(rdata_b[15:8]), 32'h3C);

    // Collision on index 7, via a mirrored write address.
    wen = 1'b1; waddr = 16'h0007; wdata = 8'h11;
    @(negedge clk);
    waddr = 16'h0807; wdata = 8'h22;
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 3; p++) ra[d][p] = 16'h0007;
    @(negedge clk);
    wen = 1'b0;
    for (int p = 0; p < NP_A; p++) check("coll_wf_a", 32'(rdata_a[p*DW +: DW]), 32'h22);
    @(negedge clk);
    check("coll_rf_b_p0", 32'(rdata_b[7:0]),  32'h11);
    check("coll_rf_b_p1", 32'(rdata_b[15:8]), 32'h11);
    @(negedge clk);
    check("coll_after_b", 32'(rdata_b[7:0]),  32'h22);

    // Two-cycle latency sweep on B.
    for (int i = 0; i < 4; i++) begin
      wen = 1'b1; waddr = 16'(i); wdata = 8'(8'h40 + i);
      @(negedge clk);
    end
    wen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) ra[1][0] = 16'(i);
      @(negedge clk);
      if (i >= 1 && i <= 4) check("lat2_sweep", 32'(rdata_b[7:0]), 32'(8'h40 + i - 1));
    end

    // Port independence on A while writing a fourth index.
    for (int i = 3; i < 6; i++) begin
      wen = 1'b1; waddr = 16'(16'h1000 | i); wdata = 8'(i * 17);
      @(negedge clk);
    end
    ra[0][0] = 16'h0003; ra[0][1] = 16'h0814; ra[0][2] = 16'h1005;
    wen = 1'b1; waddr = 16'h0006; wdata = 8'h66;
    @(negedge clk);
    wen = 1'b0;
    check("indep_p0", 32'(rdata_a[7:0]),   32'h33);
    check("indep_p1", 32'(rdata_a[15:8]),  32'h44);
    check("indep_p2", 32'(rdata_a[23:16]), 32'h55);

    // Randomised traffic with a reset in the middle.
    for (int c = 0; c < 600; c++) begin
      rst_n = !(c == 300 || c == 301);
      wen   = 1'($urandom);
      waddr = {5'($urandom), 6'd0, 5'($urandom_range(0, 7))};
      wdata = 8'($urandom);
      for (int d = 0; d < 2; d++)
        for (int p = 0; p < 3; p++)
          ra[d][p] = {5'($urandom), 6'd0, 5'($urandom_range(0, 7))};
      @(negedge clk);
    end
    wen = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
